// File: rtl/alu_result_buffer.sv
// alu_result_buffer
// Execute-to-memory stage register behind the RV32I ALU. A two-entry skid
// buffer (main + skid) sits under a valid/ready handshake, and the block also
// emits a one-cycle branch-redirect pulse for accepted taken branches.
//
// Ports:
//   clk, reset         core clock; asynchronous active-high reset
//   flush              synchronous discard of buffered entries and same-cycle input
//   in_valid/in_ready  upstream handshake (in_ready registered, 0 during reset)
//   in_*               ALU result, branch info, destination register, control bits
//   out_valid/out_ready downstream handshake for the head (main) entry
//   out_*              head entry fields
//   redirect_valid/pc  one-cycle pulse and target for an accepted taken branch
//   occupancy          number of entries held (0..2), registered
module alu_result_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_alu_out,
    input  logic                  in_branch_enable,
    input  logic                  in_is_branch,
    input  logic [DATA_WIDTH-1:0] in_branch_target,
    input  logic [RD_WIDTH-1:0]   in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_alu_out,
    output logic [RD_WIDTH-1:0]   out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [1:0]            occupancy
);

    logic                  main_valid;
    logic                  skid_valid;
    logic                  main_valid_n;
    logic                  skid_valid_n;

    logic [DATA_WIDTH-1:0] main_alu_out;
    logic [RD_WIDTH-1:0]   main_rd;
    logic                  main_reg_write;
    logic                  main_mem_read;
    logic                  main_mem_write;

    logic [DATA_WIDTH-1:0] skid_alu_out;
    logic [RD_WIDTH-1:0]   skid_rd;
    logic                  skid_reg_write;
    logic                  skid_mem_read;
    logic                  skid_mem_write;

    logic                  accept;
    logic                  fire;
    logic                  taken;
    logic                  load_main_in;
    logic                  load_main_skid;
    logic                  load_skid;

    // in_ready depends only on the registered skid bit, so there is no
    // combinational path from out_ready back upstream.
    assign in_ready  = ~skid_valid & ~reset;
    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready & ~flush;
    assign fire      = main_valid & out_ready;
    assign taken     = accept & in_is_branch & in_branch_enable;

    assign out_alu_out   = main_alu_out;
    assign out_rd        = main_rd;
    assign out_reg_write = main_reg_write;
    assign out_mem_read  = main_mem_read;
    assign out_mem_write = main_mem_write;

    always_comb begin
        main_valid_n   = main_valid;
        skid_valid_n   = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!main_valid) begin
            if (accept) begin
                main_valid_n = 1'b1;
                load_main_in = 1'b1;
            end
        end else if (fire) begin
            if (skid_valid) begin
                // Skid holds the younger entry; it advances before any new input.
                load_main_skid = 1'b1;
                skid_valid_n   = 1'b0;
            end else if (accept) begin
                load_main_in = 1'b1;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid     <= 1'b0;
            skid_valid     <= 1'b0;
            occupancy      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            main_valid     <= main_valid_n;
            skid_valid     <= skid_valid_n;
            occupancy      <= 2'(main_valid_n) + 2'(skid_valid_n);
            redirect_valid <= taken;
            if (taken) begin
                redirect_pc <= in_branch_target;
            end
        end
    end

    // Payload registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (load_main_in) begin
            main_alu_out   <= in_alu_out;
            main_rd        <= in_rd;
            main_reg_write <= in_reg_write;
            main_mem_read  <= in_mem_read;
            main_mem_write <= in_mem_write;
        end else if (load_main_skid) begin
            main_alu_out   <= skid_alu_out;
            main_rd        <= skid_rd;
            main_reg_write <= skid_reg_write;
            main_mem_read  <= skid_mem_read;
            main_mem_write <= skid_mem_write;
        end
        if (load_skid) begin
            skid_alu_out   <= in_alu_out;
            skid_rd        <= in_rd;
            skid_reg_write <= in_reg_write;
            skid_mem_read  <= in_mem_read;
            skid_mem_write <= in_mem_write;
        end
    end

endmodule
